// File: rtl/gate_sched_pkg.sv
// Shared opcode constants and FSM state encoding for the gate round-robin scheduler.
package gate_sched_pkg;

   localparam logic [1:0] OP_AND = 2'b00;
   localparam logic [1:0] OP_OR  = 2'b01;
   localparam logic [1:0] OP_NOT = 2'b10;
   localparam logic [1:0] OP_XOR = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/gate_rr_scheduler_gate_unit.sv
// Combinational AND/OR/NOT gate datapath shared by all requesters.
// GATE_SCHED_XOR_EN adds an XOR path for opcode 11; otherwise that opcode flags err.
module gate_unit
   import gate_sched_pkg::*;
#(
   parameter int W = 8
) (
   input  logic [1:0]   op,
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   output logic [W-1:0] out,
   output logic         err
);

   always_comb begin
      out = '0;
      err = 1'b0;
      unique case (op)
         OP_AND: out = x & y;
         OP_OR:  out = x | y;
         OP_NOT: out = ~x;
         OP_XOR: begin
`ifdef GATE_SCHED_XOR_EN
            out = x ^ y;
`else
            err = 1'b1;
`endif
         end
         default: err = 1'b1;
      endcase
   end

endmodule

// File: rtl/gate_rr_scheduler.sv
// Round-robin scheduler sharing one gate_unit among NREQ valid/ready requesters.
// Define GATE_SCHED_XOR_EN to execute opcode 11 as XOR instead of returning an error.
module gate_rr_scheduler
   import gate_sched_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int W = 8,
   localparam int IDW = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [2*NREQ-1:0] req_op,
   input  logic [W*NREQ-1:0] req_x,
   input  logic [W*NREQ-1:0] req_y,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [IDW-1:0]    rsp_id,
   output logic [W-1:0]      rsp_out,
   output logic              rsp_err
);

   state_t         state_q;
   state_t         state_d;
   logic [IDW-1:0] rr_ptr;
   logic [IDW-1:0] win_id;
   logic [IDW-1:0] grant_id;
   logic [IDW:0]   cand_w;
   logic           any_valid;
   logic           accept;
   logic           rsp_fire;
   logic [1:0]     sel_op;
   logic [W-1:0]   sel_x;
   logic [W-1:0]   sel_y;
   logic [1:0]     op_q;
   logic [W-1:0]   x_q;
   logic [W-1:0]   y_q;
   logic [W-1:0]   gu_out;
   logic           gu_err;

   // Search upward from the pointer, wrapping modulo NREQ; first valid requester wins.
   always_comb begin
      any_valid = 1'b0;
      win_id    = '0;
      cand_w    = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand_w = {1'b0, rr_ptr} + (IDW+1)'(k);
         if (cand_w >= (IDW+1)'(NREQ)) begin
            cand_w = cand_w - (IDW+1)'(NREQ);
         end
         if (!any_valid && req_valid[cand_w[IDW-1:0]]) begin
            any_valid = 1'b1;
            win_id    = cand_w[IDW-1:0];
         end
      end
   end

   always_comb begin
      sel_op = '0;
      sel_x  = '0;
      sel_y  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win_id == IDW'(i)) begin
            sel_op = req_op[2*i +: 2];
            sel_x  = req_x[W*i +: W];
            sel_y  = req_y[W*i +: W];
         end
      end
   end

   assign accept   = (state_q == IDLE) && any_valid && !rst;
   assign rsp_fire = (state_q == RESP) && rsp_ready;

   // Gating with rst keeps req_ready low while reset is held even though IDLE is combinational.
   always_comb begin
      req_ready = '0;
      if (accept) begin
         req_ready[win_id] = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = EXEC;
            end
         end
         EXEC: state_d = RESP;
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant_id <= '0;
         op_q     <= OP_AND;
         x_q      <= '0;
         y_q      <= '0;
      end else if (accept) begin
         grant_id <= win_id;
         op_q     <= sel_op;
         x_q      <= sel_x;
         y_q      <= sel_y;
      end
   end

   gate_unit #(
      .W (W)
   ) u_gate_unit (
      .op  (op_q),
      .x   (x_q),
      .y   (y_q),
      .out (gu_out),
      .err (gu_err)
   );

   // Result registers load only in EXEC, so they hold steady through any RESP stall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_out <= '0;
         rsp_err <= 1'b0;
         rsp_id  <= '0;
      end else if (state_q == EXEC) begin
         rsp_out <= gu_out;
         rsp_err <= gu_err;
         rsp_id  <= grant_id;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr <= '0;
      end else if (rsp_fire) begin
         if (grant_id == IDW'(NREQ-1)) begin
            rr_ptr <= '0;
         end else begin
            rr_ptr <= grant_id + 1'b1;
         end
      end
   end

   assign rsp_valid = (state_q == RESP);

endmodule

// File: tb/tb_gate_rr_scheduler.sv
// Randomized self-checking bench for gate_rr_scheduler against a transaction-level model.
module tb_gate_rr_scheduler;

   localparam int NREQ = 4;
   localparam int W = 8;
   localparam int IDW = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [2*NREQ-1:0] req_op;
   logic [W*NREQ-1:0] req_x;
   logic [W*NREQ-1:0] req_y;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [IDW-1:0]    rsp_id;
   logic [W-1:0]      rsp_out;
   logic              rsp_err;

   int vector_count = 0;
   int miss_count = 0;
   int model_ptr = 0;
   int cycle_count = 0;

   gate_rr_scheduler #(
      .NREQ (NREQ),
      .W    (W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_x     (req_x),
      .req_y     (req_y),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_out   (rsp_out),
      .rsp_err   (rsp_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle_count <= cycle_count + 1;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      vector_count++;
      if (actual !== expected) begin
         miss_count++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   function automatic int model_winner(input logic [NREQ-1:0] v);
      for (int k = 0; k < NREQ; k++) begin
         if (v[(model_ptr + k) % NREQ]) return (model_ptr + k) % NREQ;
      end
      return -1;
   endfunction

   // Returns {err, out}.
   function automatic logic [W:0] model_gate(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
      case (op)
         2'b00: return {1'b0, x & y};
         2'b01: return {1'b0, x | y};
         2'b10: return {1'b0, ~x};
         default: begin
`ifdef GATE_SCHED_XOR_EN
            return {1'b0, x ^ y};
`else
            return {1'b1, {W{1'b0}}};
`endif
         end
      endcase
   endfunction

   // Entered and left just after a falling edge with the DUT expected in IDLE.
   task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic [2*NREQ-1:0] ops,
                                input logic [W*NREQ-1:0] xs, input logic [W*NREQ-1:0] ys,
                                input int stall, input bit reset_in_exec,
                                output int obs_id, output int obs_cycle, output logic [W:0] obs_res);
      int g;
      logic [W:0] ex;
      obs_id = -1;
      obs_cycle = -1;
      obs_res = '0;
      req_valid = valid;
      req_op = ops;
      req_x = xs;
      req_y = ys;
      rsp_ready = (stall == 0);
      #1;
      g = model_winner(valid);
      if (g < 0) begin
         checkOutput("idle_ready_none", 32'(req_ready), 32'd0);
         @(negedge clk); #1;
         checkOutput("idle_stay_valid", 32'(rsp_valid), 32'd0);
         return;
      end
      checkOutput("grant", 32'(req_ready), 32'd1 << g);
      ex = model_gate(ops[2*g +: 2], xs[W*g +: W], ys[W*g +: W]);
      @(negedge clk);
      req_op = 8'($urandom);
      req_x = $urandom;
      req_y = $urandom;
      #1;
      checkOutput("exec_ready", 32'(req_ready), 32'd0);
      checkOutput("exec_rsp_valid", 32'(rsp_valid), 32'd0);
      if (reset_in_exec) begin
         rst = 1'b1;
         #1;
         checkOutput("rst_ready", 32'(req_ready), 32'd0);
         checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
         checkOutput("rst_rsp_id", 32'(rsp_id), 32'd0);
         checkOutput("rst_rsp_out", 32'(rsp_out), 32'd0);
         checkOutput("rst_rsp_err", 32'(rsp_err), 32'd0);
         @(negedge clk);
         rst = 1'b0;
         model_ptr = 0;
         #1;
         checkOutput("post_rst_valid", 32'(rsp_valid), 32'd0);
         return;
      end
      @(negedge clk); #1;
      obs_id = int'(rsp_id);
      obs_cycle = cycle_count;
      obs_res = {rsp_err, rsp_out};
      for (int c = 0; c <= stall; c++) begin
         checkOutput("rsp_valid", 32'(rsp_valid), 32'd1);
         checkOutput("rsp_id", 32'(rsp_id), 32'(g));
         checkOutput("rsp_out", 32'(rsp_out), 32'(ex[W-1:0]));
         checkOutput("rsp_err", 32'(rsp_err), 32'(ex[W]));
         checkOutput("resp_ready", 32'(req_ready), 32'd0);
         rsp_ready = (c == stall);
         if (c < stall) req_valid = NREQ'($urandom);
         @(negedge clk); #1;
      end
      model_ptr = (g + 1) % NREQ;
      checkOutput("after_rsp_valid", 32'(rsp_valid), 32'd0);
      rsp_ready = 1'b0;
   endtask

   task automatic single_request(input int i, input logic [1:0] op, input logic [W-1:0] x,
                                 input logic [W-1:0] y, input int stall, input bit reset_in_exec,
                                 output int obs_id, output int obs_cycle, output logic [W:0] obs_res);
      logic [2*NREQ-1:0] ops;
      logic [W*NREQ-1:0] xs;
      logic [W*NREQ-1:0] ys;
      ops = 8'($urandom);
      xs = $urandom;
      ys = $urandom;
      ops[2*i +: 2] = op;
      xs[W*i +: W] = x;
      ys[W*i +: W] = y;
      applyStimulus(NREQ'(1) << i, ops, xs, ys, stall, reset_in_exec, obs_id, obs_cycle, obs_res);
   endtask

   initial begin
      int id;
      int cyc;
      int prev_cyc;
      logic [W:0] res;
      int fair_ids[5] = '{0, 1, 2, 3, 0};

      rst = 1'b1;
      req_valid = '1;
      req_op = '0;
      req_x = '0;
      req_y = '0;
      rsp_ready = 1'b0;
      #1;
      checkOutput("reset_ready", 32'(req_ready), 32'd0);
      checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("reset_rsp_id", 32'(rsp_id), 32'd0);
      checkOutput("reset_rsp_out", 32'(rsp_out), 32'd0);
      checkOutput("reset_rsp_err", 32'(rsp_err), 32'd0);
      repeat (2) @(negedge clk);
      req_valid = '0;
      rst = 1'b0;
      #1;

      single_request(2, 2'b00, 8'hF0, 8'h3C, 0, 1'b0, id, cyc, res);
      checkOutput("and_id", 32'(id), 32'd2);
      checkOutput("and_res", 32'(res), 32'h030);

      single_request(0, 2'b01, 8'hA5, 8'h0F, 0, 1'b0, id, cyc, res);
      checkOutput("or_res", 32'(res), 32'h0AF);
      single_request(0, 2'b10, 8'hA5, 8'h0F, 0, 1'b0, id, cyc, res);
      checkOutput("not_res", 32'(res), 32'h05A);
      single_request(0, 2'b10, 8'hA5, 8'hFF, 0, 1'b0, id, cyc, res);
      checkOutput("not_res_y_ff", 32'(res), 32'h05A);
      single_request(0, 2'b11, 8'hFF, 8'h0F, 0, 1'b0, id, cyc, res);
`ifdef GATE_SCHED_XOR_EN
      checkOutput("op11_res", 32'(res), 32'h0F0);
`else
      checkOutput("op11_res", 32'(res), 32'h100);
`endif

      // Requester 3 moves the pointer back to 0 before the fairness run.
      single_request(3, 2'b00, 8'h55, 8'hFF, 1, 1'b0, id, cyc, res);
      prev_cyc = -1;
      for (int n = 0; n < 5; n++) begin
         applyStimulus('1, 8'($urandom), $urandom, $urandom, 0, 1'b0, id, cyc, res);
         checkOutput("fair_order", 32'(id), 32'(fair_ids[n]));
         if (n > 0) checkOutput("fair_gap", 32'(cyc - prev_cyc), 32'd3);
         prev_cyc = cyc;
      end

      single_request(1, 2'b01, 8'h12, 8'h40, 5, 1'b0, id, cyc, res);
      checkOutput("bp_res", 32'(res), 32'h052);

      // Pointer is 2 here; after reset the first grant among {1,2} must be 1.
      single_request(3, 2'b00, 8'hFF, 8'hFF, 0, 1'b1, id, cyc, res);
      applyStimulus(4'b0110, 8'h00, $urandom, $urandom, 0, 1'b0, id, cyc, res);
      checkOutput("post_rst_grant", 32'(id), 32'd1);

      for (int n = 0; n < 60; n++) begin
         applyStimulus(NREQ'($urandom), 8'($urandom), $urandom, $urandom,
                       int'($urandom_range(0, 3)), 1'b0, id, cyc, res);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
      $finish;
   end

endmodule
